router_pkt_tx: RTL

//  Packet source for the router input port. Buffers one host packet (addr, len, payload

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_tx_buf.sv | 23 ++
 rtl/router_pkt_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router input-port packet source.
package router_pkg;

    localparam int ADDR_W_DEF   = 2;
    localparam int LEN_W_DEF    = 6;
    localparam int ERR_WAIT_DEF = 3;

    // Header byte layout: {len, addr}, addr in the low bits.
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = ADDR_W_DEF;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_FILL     = 6'b000010,
        S_HEADER   = 6'b000100,
        S_PAYLOAD  = 6'b001000,
        S_PARITY   = 6'b010000,
        S_WAIT_ERR = 6'b100000
    } tx_state_t;

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module router_tx_buf #(
    parameter int LEN_W = 6
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem_q [2**LEN_W];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers one host packet and serialises header, payload and parity to the router.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int ERR_WAIT = ERR_WAIT_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [7:0]        pl_data,
    input  logic              busy,
    input  logic              err,
    output logic              pkt_valid,
    output logic [7:0]        data_out,
    output logic              done,
    output logic              err_flag,
    output logic              drop
);

    localparam int WC_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

    tx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]        par_q, par_d;
    logic              req_ready_q, req_ready_d;
    logic              pl_ready_q, pl_ready_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              done_q, done_d;
    logic              err_flag_q, err_flag_d;
    logic              drop_q, drop_d;

    logic              wr_en;
    logic [LEN_W-1:0]  rd_idx;
    logic [7:0]        rd_data;
    logic [LEN_W-1:0]  last_idx;

    assign last_idx = len_q - LEN_W'(1);

    // Read address is the byte that goes out after the current one is accepted.
    assign rd_idx = (state_q == S_HEADER) ? '0 : idx_q + LEN_W'(1);

    router_tx_buf #(
        .LEN_W (LEN_W)
    ) u_buf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (cnt_q),
        .wr_data (pl_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        par_d       = par_q;
        req_ready_d = req_ready_q;
        pl_ready_d  = pl_ready_q;
        pkt_valid_d = pkt_valid_q;
        data_out_d  = data_out_q;
        done_d      = 1'b0;
        err_flag_d  = err_flag_q;
        drop_d      = drop_q;
        wr_en       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    par_d  = 8'({req_len, req_addr});
                    cnt_d  = '0;
                    if (req_len == '0) begin
                        done_d = 1'b1;
                        drop_d = 1'b1;
                    end else begin
                        state_d     = S_FILL;
                        req_ready_d = 1'b0;
                        pl_ready_d  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (pl_valid && pl_ready_q) begin
                    wr_en = 1'b1;
                    par_d = par_q ^ pl_data;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == last_idx) begin
                        state_d     = S_HEADER;
                        pl_ready_d  = 1'b0;
                        pkt_valid_d = 1'b1;
                        data_out_d  = 8'({len_q, addr_q});
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    state_d    = S_PAYLOAD;
                    idx_d      = '0;
                    data_out_d = rd_data;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (idx_q == last_idx) begin
                        state_d     = S_PARITY;
                        pkt_valid_d = 1'b0;
                        data_out_d  = par_q;
                    end else begin
                        idx_d      = idx_q + LEN_W'(1);
                        data_out_d = rd_data;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d    = S_WAIT_ERR;
                    wcnt_d     = '0;
                    data_out_d = '0;
                end
            end
            S_WAIT_ERR: begin
                wcnt_d = wcnt_q + WC_W'(1);
                if (wcnt_q == WC_W'(ERR_WAIT - 1)) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    err_flag_d  = err;
                    drop_d      = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                pl_ready_d  = 1'b0;
                pkt_valid_d = 1'b0;
                data_out_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            par_q       <= '0;
            req_ready_q <= 1'b1;
            pl_ready_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= '0;
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            par_q       <= par_d;
            req_ready_q <= req_ready_d;
            pl_ready_q  <= pl_ready_d;
            pkt_valid_q <= pkt_valid_d;
            data_out_q  <= data_out_d;
            done_q      <= done_d;
            err_flag_q  <= err_flag_d;
            drop_q      <= drop_d;
        end
    end

    assign req_ready = req_ready_q;
    assign pl_ready  = pl_ready_q;
    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign err_flag  = err_flag_q;
    assign drop      = drop_q;

endmodule
